// File: rtl/arm7tdmi_wb_retire_queue_if.sv
// Bus bundle for the write-back retire queue: allocation, late completion, retire/exception
// outputs and the forwarding lookup. The queue uses the slave modport.
interface arm7tdmi_wb_retire_queue_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 2
);
    logic              alloc_valid;
    logic              alloc_ready;
    logic [3:0]        alloc_rd;
    logic              alloc_we;
    logic              alloc_done;
    logic [DATA_W-1:0] alloc_data;
    logic [DATA_W-1:0] alloc_pc;
    logic              alloc_exc;
    logic [DATA_W-1:0] alloc_vec;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cpl_valid;
    logic [TAG_W-1:0]  cpl_tag;
    logic [DATA_W-1:0] cpl_data;
    logic              stall;
    logic              flush;
    logic              rf_write_enable;
    logic [3:0]        rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic              instr_retire;
    logic [DATA_W-1:0] retire_pc;
    logic [31:0]       retire_instr_count;
    logic              exception_taken;
    logic [DATA_W-1:0] exception_vector;
    logic              pipeline_flush;
    logic [3:0]        fwd_query_addr;
    logic              fwd_hit;
    logic              fwd_pending;
    logic [DATA_W-1:0] fwd_data;
    logic [TAG_W:0]    occupancy;

    modport master (
        output alloc_valid, alloc_rd, alloc_we, alloc_done, alloc_data, alloc_pc, alloc_exc,
        output alloc_vec, cpl_valid, cpl_tag, cpl_data, stall, flush, fwd_query_addr,
        input  alloc_ready, alloc_tag, rf_write_enable, rf_write_addr, rf_write_data,
        input  instr_retire, retire_pc, retire_instr_count, exception_taken, exception_vector,
        input  pipeline_flush, fwd_hit, fwd_pending, fwd_data, occupancy
    );

    modport slave (
        input  alloc_valid, alloc_rd, alloc_we, alloc_done, alloc_data, alloc_pc, alloc_exc,
        input  alloc_vec, cpl_valid, cpl_tag, cpl_data, stall, flush, fwd_query_addr,
        output alloc_ready, alloc_tag, rf_write_enable, rf_write_addr, rf_write_data,
        output instr_retire, retire_pc, retire_instr_count, exception_taken, exception_vector,
        output pipeline_flush, fwd_hit, fwd_pending, fwd_data, occupancy
    );
endinterface

// File: rtl/arm7tdmi_wb_retire_queue.sv
// In-order retirement buffer: out-of-order completion by tag, in-order retire, precise
// exceptions. Define WB_FORWARD_EN to build the forwarding search; otherwise fwd_* are 0.
module arm7tdmi_wb_retire_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = $clog2(DEPTH)
) (
    input logic                       clk,
    input logic                       rst_n,
    arm7tdmi_wb_retire_queue_if.slave bus
);
    logic [DEPTH-1:0]  valid_q, done_q, we_q, exc_q;
    logic [3:0]        rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] pc_q   [DEPTH];
    logic [DATA_W-1:0] vec_q  [DEPTH];

    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]    occ_q, occ_d;

    logic              rf_we_q, rf_we_d, retire_q, retire_d, exc_q_o, exc_d_o, pflush_q, pflush_d;
    logic [3:0]        rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d, rpc_q, rpc_d, evec_q, evec_d;
    logic [31:0]       cnt_q, cnt_d;

    logic retire_go, exc_go, pop, full, alloc_go, cpl_go;

    // An excepting head kills everything younger, so it also blocks allocation that cycle.
    assign retire_go = !bus.stall && valid_q[head_q] && done_q[head_q];
    assign exc_go    = retire_go && exc_q[head_q];
    assign pop       = retire_go && !exc_go;
    assign full      = (occ_q == (TAG_W+1)'(DEPTH));
    assign alloc_go  = bus.alloc_valid && bus.alloc_ready;
    assign cpl_go    = bus.cpl_valid && valid_q[bus.cpl_tag] && !done_q[bus.cpl_tag];

    assign bus.alloc_ready = !full && !exc_go;
    assign bus.alloc_tag   = tail_q;
    assign bus.occupancy   = occ_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
        end else if (bus.flush || exc_go) begin
            valid_q <= '0;
        end else begin
            if (cpl_go) begin
                done_q[bus.cpl_tag] <= 1'b1;
                data_q[bus.cpl_tag] <= bus.cpl_data;
            end
            if (pop) valid_q[head_q] <= 1'b0;
            if (alloc_go) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= bus.alloc_done;
                we_q[tail_q]    <= bus.alloc_we;
                exc_q[tail_q]   <= bus.alloc_exc;
                rd_q[tail_q]    <= bus.alloc_rd;
                data_q[tail_q]  <= bus.alloc_data;
                pc_q[tail_q]    <= bus.alloc_pc;
                vec_q[tail_q]   <= bus.alloc_vec;
            end
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (bus.flush || exc_go) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (pop)      head_d = head_q + TAG_W'(1);
            if (alloc_go) tail_d = tail_q + TAG_W'(1);
            unique case ({alloc_go, pop})
                2'b10:   occ_d = occ_q + (TAG_W+1)'(1);
                2'b01:   occ_d = occ_q - (TAG_W+1)'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = '0;
        rf_data_d = '0;
        retire_d  = 1'b0;
        rpc_d     = '0;
        exc_d_o   = 1'b0;
        evec_d    = '0;
        pflush_d  = 1'b0;
        cnt_d     = cnt_q;
        if (!bus.flush && retire_go) begin
            if (exc_go) begin
                exc_d_o  = 1'b1;
                evec_d   = vec_q[head_q];
                pflush_d = 1'b1;
            end else begin
                retire_d  = 1'b1;
                rpc_d     = pc_q[head_q];
                rf_we_d   = we_q[head_q];
                rf_addr_d = rd_q[head_q];
                rf_data_d = data_q[head_q];
                pflush_d  = we_q[head_q] && (rd_q[head_q] == 4'd15);
                cnt_d     = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            retire_q  <= 1'b0;
            rpc_q     <= '0;
            exc_q_o   <= 1'b0;
            evec_q    <= '0;
            pflush_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            retire_q  <= retire_d;
            rpc_q     <= rpc_d;
            exc_q_o   <= exc_d_o;
            evec_q    <= evec_d;
            pflush_q  <= pflush_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.rf_write_enable    = rf_we_q;
    assign bus.rf_write_addr      = rf_addr_q;
    assign bus.rf_write_data      = rf_data_q;
    assign bus.instr_retire       = retire_q;
    assign bus.retire_pc          = rpc_q;
    assign bus.retire_instr_count = cnt_q;
    assign bus.exception_taken    = exc_q_o;
    assign bus.exception_vector   = evec_q;
    assign bus.pipeline_flush     = pflush_q;

`ifdef WB_FORWARD_EN
    logic [TAG_W-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest matching producer wins.
    always_comb begin
        bus.fwd_hit     = 1'b0;
        bus.fwd_pending = 1'b0;
        bus.fwd_data    = '0;
        fwd_idx         = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + TAG_W'(k);
            if (valid_q[fwd_idx] && we_q[fwd_idx] && (rd_q[fwd_idx] == bus.fwd_query_addr)) begin
                bus.fwd_hit     = done_q[fwd_idx];
                bus.fwd_pending = !done_q[fwd_idx];
                bus.fwd_data    = done_q[fwd_idx] ? data_q[fwd_idx] : '0;
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd      = ^bus.fwd_query_addr;
    assign bus.fwd_hit     = 1'b0;
    assign bus.fwd_pending = 1'b0;
    assign bus.fwd_data    = '0;
`endif
endmodule
